// File: rtl/control_panel_input.sv
// control_panel_input: debounced front-panel buttons and sensor feeding a run/speed FSM.
// Optional CTRL_AUTO_OFF_EN adds an inactivity timeout that drops RUN back to OFF.
module control_panel_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20,
   parameter logic [1:0]  DEFAULT_SPEED   = 2'd2,
   parameter logic [1:0]  MAX_SPEED_CODE  = 2'd2,
   parameter logic [31:0] AUTO_OFF_CYCLES = 32'd1500000000
) (
   input  logic clk_50MHz,
   input  logic rst_n,
   input  logic btn_power_n,
   input  logic btn_up_n,
   input  logic btn_down_n,
   input  logic sensor_raw,
   output logic on_off,
   output logic vel_1,
   output logic vel_0,
   output logic sensor_p,
   output logic cmd_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      S_OFF,
      S_RUN
   } state_t;

   // bit order: 0 power, 1 up, 2 down, 3 sensor
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       deb;
   logic [2:0]       deb_q;
   logic [CNT_W-1:0] cnt [4];
   logic [2:0]       press;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] speed_q;
   logic [1:0] speed_d;
   logic       pulse_d;
   logic       timeout;

   assign raw = {sensor_raw, btn_down_n, btn_up_n, btn_power_n};

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         deb_q <= '1;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb[2:0];
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // one-cycle strobe on the debounced falling edge of each button
   assign press = deb_q & ~deb[2:0];

`ifdef CTRL_AUTO_OFF_EN
   logic [31:0] timer_q;

   assign timeout = (state_q == S_RUN) &&
                    (timer_q == AUTO_OFF_CYCLES - 32'd1);

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if (state_d != S_RUN || state_q != S_RUN || |press) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      pulse_d = 1'b0;
      case (state_q)
         S_OFF: begin
            if (press[0]) begin
               state_d = S_RUN;
               speed_d = DEFAULT_SPEED;
               pulse_d = 1'b1;
            end
         end
         S_RUN: begin
            if (press[0] || timeout) begin
               state_d = S_OFF;
               pulse_d = 1'b1;
            end else if (press[1] && !press[2] && speed_q != 2'd0) begin
               speed_d = speed_q - 2'd1;
               pulse_d = 1'b1;
            end else if (press[2] && !press[1] &&
                         speed_q < MAX_SPEED_CODE) begin
               speed_d = speed_q + 2'd1;
               pulse_d = 1'b1;
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_OFF;
         speed_q   <= DEFAULT_SPEED;
         cmd_pulse <= 1'b0;
      end else begin
         state_q   <= state_d;
         speed_q   <= speed_d;
         cmd_pulse <= pulse_d;
      end
   end

   assign on_off   = (state_q == S_RUN);
   assign vel_1    = speed_q[1];
   assign vel_0    = speed_q[0];
   assign sensor_p = deb[3];

endmodule

// File: tb/tb_control_panel_input.sv
// tb_control_panel_input: directed and random pin stimulus against a
// stable-window debounce model and a plain run/speed state model.
module tb_control_panel_input;

   localparam int         D    = 4;
   localparam int         AUTO = 50;
   localparam logic [1:0] DEF  = 2'd2;
   localparam logic [1:0] MAX  = 2'd2;

   logic       clk_50MHz = 1'b0;
   logic       rst_n     = 1'b0;
   logic [3:0] pins      = '1;
   logic       on_off;
   logic       vel_1;
   logic       vel_0;
   logic       sensor_p;
   logic       cmd_pulse;
   logic [4:0] got_v;

   always #5 clk_50MHz = ~clk_50MHz;

   control_panel_input #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(3),
      .DEFAULT_SPEED(DEF),
      .MAX_SPEED_CODE(MAX),
      .AUTO_OFF_CYCLES(32'(AUTO))
   ) dut (
      .clk_50MHz(clk_50MHz),
      .rst_n(rst_n),
      .btn_power_n(pins[0]),
      .btn_up_n(pins[1]),
      .btn_down_n(pins[2]),
      .sensor_raw(pins[3]),
      .on_off(on_off),
      .vel_1(vel_1),
      .vel_0(vel_0),
      .sensor_p(sensor_p),
      .cmd_pulse(cmd_pulse)
   );

   assign got_v = {on_off, vel_1, vel_0, sensor_p, cmd_pulse};

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // reference model: raw pin samples per edge, debounced value flips
   // once D consecutive synchronised samples all disagree with it
   logic [3:0] hist[$];
   logic [3:0] m_deb;
   logic [2:0] m_pend;
   bit         m_on;
   logic [1:0] m_spd;
   bit         m_pulse;
   int         m_timer;

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
      m_deb   = 4'hF;
      m_pend  = 3'b000;
      m_on    = 1'b0;
      m_spd   = DEF;
      m_pulse = 1'b0;
      m_timer = 0;
   endfunction

   function automatic void model_edge(input logic [3:0] p);
      bit         old_on;
      bit         to;
      bit         same;
      logic [2:0] np;
      old_on  = m_on;
      m_pulse = 1'b0;
`ifdef CTRL_AUTO_OFF_EN
      to = m_on && (m_timer == AUTO - 1);
`else
      to = 1'b0;
`endif
      if (!m_on) begin
         if (m_pend[0]) begin
            m_on = 1'b1; m_spd = DEF; m_pulse = 1'b1;
         end
      end else if (m_pend[0] || to) begin
         m_on = 1'b0; m_pulse = 1'b1;
      end else if (m_pend == 3'b010 && m_spd > 0) begin
         m_spd = m_spd - 1; m_pulse = 1'b1;
      end else if (m_pend == 3'b100 && m_spd < MAX) begin
         m_spd = m_spd + 1; m_pulse = 1'b1;
      end
      if (!m_on || !old_on || m_pend != 0) m_timer = 0;
      else m_timer++;
      hist.push_back(p);
      if (hist.size() > D + 2) void'(hist.pop_front());
      np = 3'b000;
      for (int i = 0; i < 4; i++) begin
         same = 1'b1;
         for (int k = 1; k < D; k++)
            if (hist[k][i] != hist[0][i]) same = 1'b0;
         if (same && hist[0][i] != m_deb[i]) begin
            m_deb[i] = hist[0][i];
            if (i < 3 && !m_deb[i]) np[i] = 1'b1;
         end
      end
      m_pend = np;
   endfunction

   task automatic cycle(input logic [3:0] p);
      logic [4:0] e;
      pins = p;
      @(posedge clk_50MHz);
      model_edge(p);
      #1;
      e = {m_on, m_spd, m_deb[3], m_pulse};
      chk("outputs", got_v, e);
   endtask

   task automatic press(input logic [3:0] p, output int npulse);
      npulse = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(i < 8 ? p : 4'hF);
         if (cmd_pulse) npulse++;
      end
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", got_v, 5'b0_10_1_0);
      model_reset();
      repeat (2) @(posedge clk_50MHz);
      #1;
      rst_n = 1'b1;
   endtask

   logic [1:0] up_exp [3] = '{2'd1, 2'd0, 2'd0};
   int         up_np  [3] = '{1, 1, 0};
   logic [1:0] dn_exp [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
   int         dn_np  [4] = '{1, 1, 0, 0};

   initial begin
      int np;
      logic [3:0] rp;
      int len;
      model_reset();
      @(posedge clk_50MHz);
      #1;
      chk("reset_state", got_v, 5'b0_10_1_0);
      rst_n = 1'b1;
      repeat (6) cycle(4'hF);
      do_reset();
      repeat (4) cycle(4'hF);

      // short glitch rejected, long hold accepted at edge 7
      repeat (3) cycle(4'b1110);
      repeat (8) cycle(4'hF);
      chk("glitch_on", on_off, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         cycle(4'b1110);
         chk("pwr_latency", on_off, k >= 7);
         if (k == 7) chk("pwr_pulse", cmd_pulse, 1'b1);
      end
      repeat (8) cycle(4'hF);

      for (int i = 0; i < 3; i++) begin
         press(4'b1101, np);
         chk("up_vel", {vel_1, vel_0}, up_exp[i]);
         chk("up_pulses", np, up_np[i]);
      end
      for (int i = 0; i < 4; i++) begin
         press(4'b1011, np);
         chk("dn_vel", {vel_1, vel_0}, dn_exp[i]);
         chk("dn_pulses", np, dn_np[i]);
      end

      press(4'b1110, np);
      chk("pwr_off", on_off, 1'b0);
      press(4'b1101, np);
      chk("off_up_vel", {vel_1, vel_0}, 2'd2);
      chk("off_up_pulse", np, 0);
      press(4'b1110, np);
      press(4'b1001, np);
      chk("updn_vel", {vel_1, vel_0}, 2'd2);
      chk("updn_pulse", np, 0);
      press(4'b1101, np);
      press(4'b1010, np);
      chk("pwr_dn_on", on_off, 1'b0);
      chk("pwr_dn_vel", {vel_1, vel_0}, 2'd1);

      for (int i = 0; i < 20; i++) cycle({i[0], 3'b111});
      for (int k = 1; k <= 10; k++) begin
         cycle(4'b0111);
         chk("sensor_lat", sensor_p, k < 6);
      end
      repeat (8) cycle(4'hF);

`ifdef CTRL_AUTO_OFF_EN
      begin
         int k_on;
         int k_off;
         k_on  = -1;
         k_off = -1;
         for (int k = 1; k <= 90; k++) begin
            cycle(k <= 8 ? 4'b1110 : 4'hF);
            if (on_off && k_on < 0) k_on = k;
            if (!on_off && k_on >= 0 && k_off < 0) k_off = k;
         end
         chk("auto_off", k_off - k_on, 50);
      end
`endif

      for (int s = 0; s < 400; s++) begin
         rp[0] = ($urandom_range(3, 0) != 0);
         rp[1] = ($urandom_range(3, 0) != 0);
         rp[2] = ($urandom_range(3, 0) != 0);
         rp[3] = ($urandom_range(1, 0) != 0);
         len = $urandom_range(12, 1);
         if ($urandom_range(99, 0) == 0) do_reset();
         repeat (len) cycle(rp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
